// File: rtl/issue_select_pkg.sv
// Shared types and constants for the dual-issue in-order select stage.
package issue_select_pkg;

  localparam int unsigned PREG_NUM_DFLT = 64;
  localparam int unsigned PREG_W        = $clog2(PREG_NUM_DFLT);
  localparam int unsigned IQ_DEPTH      = 16;
  localparam int unsigned IQ_ADDR_W     = $clog2(IQ_DEPTH) + 1;

  typedef logic [PREG_W-1:0]    preg_t;
  typedef logic [IQ_ADDR_W-1:0] IQ_ADDR;

  typedef struct packed {
    logic  valid;
    preg_t rs_preg;
    preg_t rt_preg;
    logic  rs_used;
    logic  rt_used;
    preg_t rd_preg;
    logic  rd_wen;
  } ISSUE_QUEUE_ELEMENT;

  // A source is satisfied when unused, not busy, or forwarded from writeback.
  function automatic logic src_ok(input logic used, input logic busy, input logic bypass);
    return !used || !busy || bypass;
  endfunction

endpackage

// File: rtl/issue_select_if.sv
// Issue-queue head and execute-lane handshake bundle.
interface issue_select_if;
  import issue_select_pkg::*;

  ISSUE_QUEUE_ELEMENT [1:0] iq_data;
  IQ_ADDR                   iq_size;
  logic [1:0]               issue_num;
  logic [1:0]               ex_valid;
  ISSUE_QUEUE_ELEMENT [1:0] ex_op;
  logic [1:0]               ex_ready;

  // Select stage side.
  modport master (
    input  iq_data, iq_size, ex_ready,
    output issue_num, ex_valid, ex_op
  );

  // Queue / execute environment side.
  modport slave (
    output iq_data, iq_size, ex_ready,
    input  issue_num, ex_valid, ex_op
  );

endinterface

// File: rtl/issue_select_busy_table.sv
// Per-preg busy scoreboard: 4 set ports, 2 clear ports, clear-all, 4 reads.
module busy_table
  import issue_select_pkg::*;
#(
  parameter int unsigned PREG_NUM = PREG_NUM_DFLT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             set_valid,
  input  logic [3:0][PREG_W-1:0] set_preg,
  input  logic [1:0]             clr_valid,
  input  logic [1:0][PREG_W-1:0] clr_preg,
  input  logic                   clr_all,
  input  logic [3:0][PREG_W-1:0] rd_preg,
  output logic [3:0]             rd_busy
);

  logic [PREG_NUM-1:0] busy_q;
  logic [PREG_NUM-1:0] busy_d;

  // Next busy vector: clears first so a same-cycle set wins; preg 0 pinned ready.
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < 2; j++) begin
      if (clr_valid[j]) busy_d[clr_preg[j]] = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      if (set_valid[k]) busy_d[set_preg[k]] = 1'b1;
    end
    busy_d[0] = 1'b0;
    if (clr_all) busy_d = '0;
  end

  // Busy state register.
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  // Combinational read of the registered state.
  always_comb begin
    rd_busy = '0;
    for (int k = 0; k < 4; k++) begin
      rd_busy[k] = busy_q[rd_preg[k]];
    end
  end

endmodule

// File: rtl/issue_select.sv
// In-order dual-issue select from the two oldest issue-queue entries.
// Optional feature: define ISSUE_WB_BYPASS_EN to let a same-cycle writeback
// wake a busy source without waiting for the busy bit to clear.
module issue_select
  import issue_select_pkg::*;
#(
  parameter int unsigned PREG_NUM = PREG_NUM_DFLT
) (
  input  logic                   clk,
  input  logic                   rst,
  issue_select_if.master         bus,
  input  logic [3:0]             alloc_valid,
  input  logic [3:0][PREG_W-1:0] alloc_preg,
  input  logic [1:0]             wb_valid,
  input  logic [1:0][PREG_W-1:0] wb_preg,
  input  logic                   flush
);

  ISSUE_QUEUE_ELEMENT       ent0;
  ISSUE_QUEUE_ELEMENT       ent1;
  logic [3:0][PREG_W-1:0]   src_preg;
  logic [3:0]               src_busy;
  logic [3:0]               src_byp;
  logic [1:0]               lane_free;
  logic                     ent0_ready;
  logic                     ent1_ready;
  logic                     raw_hit;
  logic                     issue0;
  logic                     issue1;
  logic [1:0]               ex_valid_q;
  ISSUE_QUEUE_ELEMENT [1:0] ex_op_q;

  assign ent0     = bus.iq_data[0];
  assign ent1     = bus.iq_data[1];
  // Read ports: 0/1 = entry0 rs/rt, 2/3 = entry1 rs/rt.
  assign src_preg = {ent1.rt_preg, ent1.rs_preg, ent0.rt_preg, ent0.rs_preg};

  busy_table #(
    .PREG_NUM (PREG_NUM)
  ) u_busy_table (
    .clk       (clk),
    .rst       (rst),
    .set_valid (alloc_valid),
    .set_preg  (alloc_preg),
    .clr_valid (wb_valid),
    .clr_preg  (wb_preg),
    .clr_all   (flush),
    .rd_preg   (src_preg),
    .rd_busy   (src_busy)
  );

`ifdef ISSUE_WB_BYPASS_EN
  // Same-cycle writeback match forwards readiness to a busy source.
  always_comb begin
    src_byp = '0;
    for (int k = 0; k < 4; k++) begin
      src_byp[k] = (wb_valid[0] && (wb_preg[0] == src_preg[k])) ||
                   (wb_valid[1] && (wb_preg[1] == src_preg[k]));
    end
  end
`else
  assign src_byp = '0;
`endif

  // Lane accepts a new op when empty or its current op is being taken.
  assign lane_free = ~ex_valid_q | bus.ex_ready;

  // Source readiness and intra-pair RAW against entry 0's destination.
  always_comb begin
    ent0_ready = src_ok(ent0.rs_used, src_busy[0], src_byp[0]) &&
                 src_ok(ent0.rt_used, src_busy[1], src_byp[1]);
    ent1_ready = src_ok(ent1.rs_used, src_busy[2], src_byp[2]) &&
                 src_ok(ent1.rt_used, src_busy[3], src_byp[3]);
    raw_hit    = ent0.rd_wen &&
                 ((ent1.rs_used && (ent0.rd_preg == ent1.rs_preg)) ||
                  (ent1.rt_used && (ent0.rd_preg == ent1.rt_preg)));
  end

  // In-order issue decision; reset and flush suppress all issue.
  always_comb begin
    issue0 = 1'b0;
    issue1 = 1'b0;
    if (!rst && !flush) begin
      issue0 = (bus.iq_size >= IQ_ADDR'(1)) && ent0.valid && ent0_ready && lane_free[0];
      issue1 = issue0 && (bus.iq_size >= IQ_ADDR'(2)) && ent1.valid && ent1_ready &&
               lane_free[1] && !raw_hit;
    end
  end

  assign bus.issue_num = {1'b0, issue0} + {1'b0, issue1};

  // Execute-lane registers: load when free, hold under back-pressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= '0;
      ex_op_q    <= '0;
    end else if (flush) begin
      ex_valid_q <= '0;
    end else begin
      if (lane_free[0]) begin
        ex_valid_q[0] <= issue0;
        ex_op_q[0]    <= bus.iq_data[0];
      end
      if (lane_free[1]) begin
        ex_valid_q[1] <= issue1;
        ex_op_q[1]    <= bus.iq_data[1];
      end
    end
  end

  assign bus.ex_valid = ex_valid_q;
  assign bus.ex_op    = ex_op_q;

endmodule

// File: tb/tb_issue_select.sv
// Scoreboard bench for issue_select: driver pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_issue_select;
  import issue_select_pkg::*;

`ifdef ISSUE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]         mask;  // 0:issue_num 1:ex_valid 2:ex_op[0] 3:ex_op[1]
    logic [1:0]         num;
    logic [1:0]         ev;
    ISSUE_QUEUE_ELEMENT op0;
    ISSUE_QUEUE_ELEMENT op1;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [3:0]             alloc_valid;
  logic [3:0][PREG_W-1:0] alloc_preg;
  logic [1:0]             wb_valid;
  logic [1:0][PREG_W-1:0] wb_preg;
  logic                   flush;

  issue_select_if bus ();

  issue_select dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .alloc_valid (alloc_valid),
    .alloc_preg  (alloc_preg),
    .wb_valid    (wb_valid),
    .wb_preg     (wb_preg),
    .flush       (flush)
  );

  always #5 clk = ~clk;

  exp_t  exp_q[$];
  string name_q[$];
  int    total  = 0;
  int    passed = 0;

  function automatic ISSUE_QUEUE_ELEMENT mk_op(input int rs, input bit rsu, input int rt,
                                               input bit rtu, input int rd, input bit rdw);
    ISSUE_QUEUE_ELEMENT e;
    e.valid   = 1'b1;
    e.rs_preg = PREG_W'(rs);
    e.rs_used = rsu;
    e.rt_preg = PREG_W'(rt);
    e.rt_used = rtu;
    e.rd_preg = PREG_W'(rd);
    e.rd_wen  = rdw;
    return e;
  endfunction

  task automatic push_exp(input string nm, input logic [3:0] m, input logic [1:0] n,
                          input logic [1:0] v, input ISSUE_QUEUE_ELEMENT o0,
                          input ISSUE_QUEUE_ELEMENT o1);
    exp_t e;
    e.mask = m;
    e.num  = n;
    e.ev   = v;
    e.op0  = o0;
    e.op1  = o1;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every pending expectation at the falling edge.
  always @(negedge clk) begin
    exp_t  e;
    string nm;
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (e.mask[0]) begin
        total++;
        if (bus.issue_num === e.num) passed++;
        else $display("FAIL %s issue_num got %0d want %0d", nm, bus.issue_num, e.num);
      end
      if (e.mask[1]) begin
        total++;
        if (bus.ex_valid === e.ev) passed++;
        else $display("FAIL %s ex_valid got %b want %b", nm, bus.ex_valid, e.ev);
      end
      if (e.mask[2]) begin
        total++;
        if (bus.ex_op[0] === e.op0) passed++;
        else $display("FAIL %s ex_op0 got %h want %h", nm, bus.ex_op[0], e.op0);
      end
      if (e.mask[3]) begin
        total++;
        if (bus.ex_op[1] === e.op1) passed++;
        else $display("FAIL %s ex_op1 got %h want %h", nm, bus.ex_op[1], e.op1);
      end
    end
  end

  // Hard time limit.
  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    ISSUE_QUEUE_ELEMENT zop, op_r, op_a, op_b0, op_b1, op_c0, op_c1, op_d0, op_d1;
    ISSUE_QUEUE_ELEMENT op_e0, op_e1, op_f0, op_f3, op_f4, op_g0, op_g1, op_g4a, op_g4b;
    zop    = '0;
    op_r   = mk_op(0, 0, 0, 0, 3, 1);
    op_a   = mk_op(5, 1, 0, 0, 10, 1);
    op_b0  = mk_op(0, 0, 0, 0, 7, 1);
    op_b1  = mk_op(7, 1, 0, 0, 11, 1);
    op_c0  = mk_op(1, 1, 2, 1, 12, 1);
    op_c1  = mk_op(3, 1, 4, 1, 13, 1);
    op_d0  = mk_op(0, 0, 0, 0, 14, 1);
    op_d1  = mk_op(0, 0, 0, 0, 15, 1);
    op_e0  = mk_op(20, 1, 0, 0, 16, 1);
    op_e1  = mk_op(0, 0, 0, 0, 17, 1);
    op_f0  = mk_op(0, 0, 9, 1, 18, 1);
    op_f3  = mk_op(0, 1, 0, 1, 19, 1);
    op_f4  = mk_op(0, 0, 0, 0, 21, 1);
    op_g0  = mk_op(0, 0, 0, 0, 22, 1);
    op_g1  = mk_op(0, 0, 0, 0, 23, 1);
    op_g4a = mk_op(9, 1, 0, 0, 24, 1);
    op_g4b = mk_op(20, 1, 30, 1, 25, 1);

    // Reset with a ready op presented: nothing issues, lanes cleared.
    rst = 1'b1; flush = 1'b0; alloc_valid = '0; alloc_preg = '0;
    wb_valid = '0; wb_preg = '0; bus.ex_ready = 2'b11;
    bus.iq_size = IQ_ADDR'(1); bus.iq_data[0] = op_r; bus.iq_data[1] = zop;
    tick; push_exp("reset", 4'b1111, 2'd0, 2'b00, zop, zop);

    // Wakeup through writeback of preg 5.
    tick; rst = 1'b0; bus.iq_size = IQ_ADDR'(0); alloc_valid = 4'b0001; alloc_preg[0] = PREG_W'(5);
    push_exp("a1_alloc", 4'b0011, 2'd0, 2'b00, zop, zop);
    tick; alloc_valid = '0; bus.iq_size = IQ_ADDR'(1); bus.iq_data[0] = op_a;
    push_exp("a2_busy", 4'b0011, 2'd0, 2'b00, zop, zop);
    tick; wb_valid = 2'b01; wb_preg[0] = PREG_W'(5);
    push_exp("a3_wb", 4'b0011, BYP ? 2'd1 : 2'd0, 2'b00, zop, zop);
    tick; wb_valid = '0;
    push_exp("a4_after_wb", 4'b0011, 2'd1, BYP ? 2'b01 : 2'b00, zop, zop);
    tick; bus.iq_size = IQ_ADDR'(0);
    push_exp("a5_lane0", 4'b0111, 2'd0, 2'b01, op_a, zop);
    tick; push_exp("a6_drain", 4'b0011, 2'd0, 2'b00, zop, zop);

    // Intra-pair RAW on preg 7.
    tick; bus.iq_size = IQ_ADDR'(2); bus.iq_data[0] = op_b0; bus.iq_data[1] = op_b1;
    push_exp("b1_raw", 4'b0011, 2'd1, 2'b00, zop, zop);
    tick; bus.iq_size = IQ_ADDR'(0);
    push_exp("b2_lane0", 4'b0111, 2'd0, 2'b01, op_b0, zop);

    // Back-pressure holds both lanes.
    tick; bus.ex_ready = 2'b00; bus.iq_size = IQ_ADDR'(2); bus.iq_data[0] = op_c0; bus.iq_data[1] = op_c1;
    push_exp("c1_dual", 4'b0011, 2'd2, 2'b00, zop, zop);
    tick; bus.iq_data[0] = op_d0; bus.iq_data[1] = op_d1;
    push_exp("c2_stall", 4'b1111, 2'd0, 2'b11, op_c0, op_c1);
    tick; push_exp("c3_stall", 4'b1111, 2'd0, 2'b11, op_c0, op_c1);
    tick; bus.ex_ready = 2'b11;
    push_exp("c4_release", 4'b1111, 2'd2, 2'b11, op_c0, op_c1);
    tick; bus.iq_size = IQ_ADDR'(0);
    push_exp("c5_next", 4'b1111, 2'd0, 2'b11, op_d0, op_d1);
    tick; push_exp("c6_drain", 4'b0011, 2'd0, 2'b00, zop, zop);

    // Oldest blocked, younger ready: no out-of-order issue.
    tick; alloc_valid = 4'b0001; alloc_preg[0] = PREG_W'(20);
    push_exp("e1_alloc", 4'b0011, 2'd0, 2'b00, zop, zop);
    tick; alloc_valid = '0; bus.iq_size = IQ_ADDR'(2); bus.iq_data[0] = op_e0; bus.iq_data[1] = op_e1;
    push_exp("e2_inorder", 4'b0011, 2'd0, 2'b00, zop, zop);
    tick; bus.iq_size = IQ_ADDR'(0);
    push_exp("e3_none", 4'b0011, 2'd0, 2'b00, zop, zop);

    // Set beats clear on preg 9; preg 0 never busy; size limits issue.
    tick; alloc_valid = 4'b0011; alloc_preg[0] = PREG_W'(9); alloc_preg[1] = PREG_W'(0);
    wb_valid = 2'b01; wb_preg[0] = PREG_W'(9);
    push_exp("f1_setclr", 4'b0011, 2'd0, 2'b00, zop, zop);
    tick; alloc_valid = '0; wb_valid = '0; bus.iq_size = IQ_ADDR'(1); bus.iq_data[0] = op_f0;
    push_exp("f2_p9_busy", 4'b0011, 2'd0, 2'b00, zop, zop);
    tick; bus.iq_data[0] = op_f3; bus.iq_data[1] = op_f4;
    push_exp("f3_p0_size1", 4'b0011, 2'd1, 2'b00, zop, zop);
    tick; bus.iq_size = IQ_ADDR'(0);
    push_exp("f4_empty", 4'b0111, 2'd0, 2'b01, op_f3, zop);

    // Flush: lanes cleared, busy table cleared, alloc ignored.
    tick; bus.ex_ready = 2'b00; bus.iq_size = IQ_ADDR'(2); bus.iq_data[0] = op_g0; bus.iq_data[1] = op_g1;
    push_exp("g1_dual", 4'b0011, 2'd2, 2'b00, zop, zop);
    tick; bus.ex_ready = 2'b11; flush = 1'b1; alloc_valid = 4'b0001; alloc_preg[0] = PREG_W'(30);
    push_exp("g2_flush", 4'b0111, 2'd0, 2'b11, op_g0, zop);
    tick; flush = 1'b0; alloc_valid = '0; bus.iq_size = IQ_ADDR'(0);
    push_exp("g3_cleared", 4'b0011, 2'd0, 2'b00, zop, zop);
    tick; bus.iq_size = IQ_ADDR'(2); bus.iq_data[0] = op_g4a; bus.iq_data[1] = op_g4b;
    push_exp("g4_all_ready", 4'b0011, 2'd2, 2'b00, zop, zop);
    tick; bus.iq_size = IQ_ADDR'(0);
    push_exp("g5_lanes", 4'b1111, 2'd0, 2'b11, op_g4a, op_g4b);

    tick;
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL drain pending got %0d want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/issue_select.md
ISSUE_SELECT -- requirements
Module: issue_select

Interface
REQ-001 SHALL have parameter PREG_NUM, default 64, number of physical registers; PREG_W = $clog2(PREG_NUM).
REQ-002 SHALL have port clk, input, 1, single clock for all state.
REQ-003 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port iq_data, input, ISSUE_QUEUE_ELEMENT[1:0], two oldest issue-queue entries; [0] is oldest.
REQ-005 SHALL have port iq_size, input, IQ_ADDR, current issue-queue occupancy.
REQ-006 SHALL have port issue_num, output, 2, entries consumed this cycle; drives the queue's pop count.
REQ-007 SHALL have ports alloc_valid, input, 4, and alloc_preg, input, [3:0][PREG_W-1:0], rename destinations to mark busy.
REQ-008 SHALL have ports wb_valid, input, 2, and wb_preg, input, [1:0][PREG_W-1:0], writeback destinations to mark ready.
REQ-009 SHALL have port flush, input, 1, pipeline flush.
REQ-010 SHALL have ports ex_valid, output, 2, and ex_op, output, ISSUE_QUEUE_ELEMENT[1:0], registered ops to the execute lanes.
REQ-011 SHALL have port ex_ready, input, 2, per-lane accept from the execute lanes.

Function
REQ-012 SHALL use these element fields: valid, rs_preg, rt_preg, rs_used, rt_used, rd_preg, rd_wen.
REQ-013 SHALL compute issue_num combinationally in the same cycle as iq_data and iq_size.
REQ-014 SHALL treat lane i as free when ex_valid[i]==0, or when ex_valid[i]==1 and ex_ready[i]==1.
REQ-015 SHALL assert issue0 when all hold: iq_size>=1; iq_data[0].valid; every used source not busy; lane 0 free.
REQ-016 SHALL assert issue1 when all hold: issue0; iq_size>=2; iq_data[1].valid; every used source not busy; lane 1 free.
REQ-017 SHALL additionally block issue1 when iq_data[0].rd_wen and iq_data[0].rd_preg equals a used source of iq_data[1]; this is an intra-pair RAW check.
REQ-018 SHALL issue strictly in order and never issue entry 1 without entry 0.
REQ-019 SHALL drive issue_num = issue0 + issue1, within 0..2.
REQ-020 SHALL, on each clk for each free lane i, load ex_valid[i] <= issue_i and ex_op[i] <= iq_data[i]; issue-to-ex latency is 1 cycle.
REQ-021 SHALL hold ex_valid[i] and ex_op[i] stable while ex_valid[i]==1 and ex_ready[i]==0.
REQ-022 SHALL keep a busy bit per physical register, updated every clk.
REQ-023 SHALL set the busy bit of alloc_preg[k] when alloc_valid[k]==1.
REQ-024 SHALL clear the busy bit of wb_preg[j] when wb_valid[j]==1.
REQ-025 SHALL let set win over clear when set and clear hit the same preg in the same cycle.
REQ-026 SHALL treat preg 0 as never busy; writes to preg 0 are ignored.
REQ-027 SHALL ignore iq_data contents beyond iq_size.
REQ-028 SHALL treat iq_size==0 as empty, giving issue_num=0.
REQ-029 SHALL, when flush==1, force issue_num=0 that cycle, clear both ex_valid bits at the next edge, and clear all busy bits.
REQ-030 SHALL give flush priority over alloc and wb in the same cycle.

Reset
REQ-031 SHALL, on rst==1 at a clk edge, set ex_valid=2'b00, ex_op=all-zero, and all busy bits=0.
REQ-032 SHALL drive issue_num=0 while rst==1, with reset taking priority over flush, alloc and wb.

Configuration
REQ-033 SHALL, with ISSUE_WB_BYPASS_EN defined, treat a source as ready if its busy bit is set but it matches a wb_preg with wb_valid in the same cycle.
REQ-034 SHALL, without ISSUE_WB_BYPASS_EN, make a source ready only the cycle after its writeback clears the busy bit, adding 1 cycle of wakeup latency.

Structure
REQ-035 SHALL take ISSUE_QUEUE_ELEMENT, IQ_ADDR and the PREG width constant from the shared defines package; no local redefinition.
REQ-036 SHALL implement the busy table as sub-module busy_table: 4 set ports, 2 clear ports, 1 clear-all, and 4 combinational read ports (rs/rt of 2 entries).

Verification
REQ-037 SHALL verify: alloc preg 5; iq_data[0] rs=5 -> issue_num=0; wb preg 5 -> issue_num=1 the next cycle, or the same cycle with ISSUE_WB_BYPASS_EN.
REQ-038 SHALL verify: iq_size=2, entry0 rd=7 rd_wen=1, entry1 rs=7 -> issue_num=1, ex_valid=2'b01 the next cycle.
REQ-039 SHALL verify: iq_size=2, independent ready ops, ex_ready=2'b00 with ex_valid=2'b11 held -> issue_num=0 and ex_op stable until ex_ready=2'b11, then issue_num=2.
REQ-040 SHALL verify: entry0 blocked by busy src while entry1 is ready -> issue_num=0; no out-of-order issue.
REQ-041 SHALL verify: alloc preg 9 and wb preg 9 in the same cycle -> preg 9 busy afterward; alloc preg 0 -> preg 0 stays ready.
REQ-042 SHALL verify: flush with ex_valid=2'b11 and busy pregs set -> ex_valid=2'b00 at the next edge, all pregs ready, and issue_num=0 in the flush cycle.
